// File: rtl/iob_mem_arb_pkg.sv
// iob_mem_arb_pkg
//   Shared definitions for iob_mem_arbiter: IOb bundle widths, field
//   offsets inside the packed request/response words, and FSM states.
//   Request word layout (MSB..LSB): {valid, addr, wdata, wstrb}
//   Response word layout (MSB..LSB): {rdata, ready}
package iob_mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Width of one packed IOb request: valid + addr + wdata + wstrb.
    function automatic int req_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w + data_w / 8;
    endfunction

    // Width of one packed IOb response: rdata + ready.
    function automatic int resp_w(input int data_w);
        return data_w + 1;
    endfunction

    // Request field offsets (LSB position of each field).
    function automatic int wstrb_off();
        return 0;
    endfunction

    function automatic int wdata_off(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int addr_off(input int data_w);
        return data_w / 8 + data_w;
    endfunction

    function automatic int valid_off(input int addr_w, input int data_w);
        return req_w(addr_w, data_w) - 1;
    endfunction

    // Response field offsets.
    function automatic int ready_off();
        return 0;
    endfunction

    function automatic int rdata_off();
        return 1;
    endfunction

endpackage

// File: rtl/iob_mem_arbiter_rr_enc.sv
// iob_rr_prio_enc
//   Combinational round-robin priority encoder. Searches the request
//   vector starting at the index just after 'last', wrapping modulo N,
//   and returns the first requester found. 'any' flags that at least
//   one request is pending; 'winner' is 0 when none is.
module iob_rr_prio_enc #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] winner,
    output logic             any
);

    // Scan offsets 1..N from 'last'; the first hit is the winner.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        winner = '0;
        any    = 1'b0;
        for (int k = 1; k <= N; k++) begin
            logic [IDX_W-1:0] idx;
            idx = IDX_W'((int'(last) + k) % N);
            if (!any && req[idx]) begin
                winner = idx;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iob_mem_arbiter.sv
// iob_mem_arbiter
//   Shares one native IOb slave port between N_MASTERS IOb masters with
//   round-robin arbitration and one outstanding transaction per grant.
//   IDLE arbitrates (one cycle), BUSY forwards the owner's request to the
//   slave and the slave's response back to the owner only. The grant is
//   released when the slave returns ready, or when the owner withdraws
//   valid before ready (tolerated abort).
//   Optional per-master grant counters: define IOB_MEM_ARB_STATS_EN.
module iob_mem_arbiter
    import iob_mem_arb_pkg::*;
#(
    parameter  int N_MASTERS = 2,
    parameter  int ADDR_W    = 32,
    parameter  int DATA_W    = 32,
    localparam int REQ_W     = req_w(ADDR_W, DATA_W),
    localparam int RESP_W    = resp_w(DATA_W),
    localparam int IDX_W     = $clog2(N_MASTERS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_MASTERS*REQ_W-1:0]  m_req,
    output logic [N_MASTERS*RESP_W-1:0] m_resp,
    output logic [REQ_W-1:0]            s_req,
    input  logic [RESP_W-1:0]           s_resp,
    output logic [IDX_W-1:0]            grant,
    output logic                        busy
`ifdef IOB_MEM_ARB_STATS_EN
    ,
    input  logic                        stat_clr,
    output logic [N_MASTERS*32-1:0]     stat_grants
`endif
);

    localparam int VALID_OFF = valid_off(ADDR_W, DATA_W);
    localparam int READY_OFF = ready_off();

    arb_state_e       state;
    arb_state_e       state_next;
    logic [IDX_W-1:0] grant_q;
    logic [IDX_W-1:0] grant_next;
    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] last_next;
    logic [IDX_W-1:0] winner;
    logic [N_MASTERS-1:0] m_valid;
    logic             any_valid;
    logic             s_ready;
    logic             owner_valid;

    // Gather every master's valid bit into one request vector.
    always_comb begin
        m_valid = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            m_valid[i] = m_req[i*REQ_W + VALID_OFF];
        end
    end

    assign s_ready     = s_resp[READY_OFF];
    assign owner_valid = m_valid[grant_q];

    iob_rr_prio_enc #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_rr_enc (
        .req    (m_valid),
        .last   (last_q),
        .winner (winner),
        .any    (any_valid)
    );

    // State, owner and last-served registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            state   <= IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(N_MASTERS - 1);
        end else begin
            state   <= state_next;
            grant_q <= grant_next;
            last_q  <= last_next;
        end
    end

    // Next-state: grant in IDLE, release on slave ready or owner abort.
    always_comb begin
        state_next = state;
        grant_next = grant_q;
        last_next  = last_q;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    state_next = BUSY;
                    grant_next = winner;
                end
            end
            BUSY: begin
                if (s_ready || !owner_valid) begin
                    state_next = IDLE;
                    last_next  = grant_q;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request/response muxes: only the owner is connected, only in BUSY.
    always_comb begin
        s_req  = '0;
        m_resp = '0;
        if (state == BUSY) begin
            for (int i = 0; i < N_MASTERS; i++) begin
                if (grant_q == IDX_W'(i)) begin
                    s_req                      = m_req[i*REQ_W +: REQ_W];
                    m_resp[i*RESP_W +: RESP_W] = s_resp;
                end
            end
        end
    end

    assign busy  = (state == BUSY);
    assign grant = grant_q;

`ifdef IOB_MEM_ARB_STATS_EN
    logic [31:0] stat_cnt [N_MASTERS];
    logic        grant_start;

    assign grant_start = (state == IDLE) && any_valid;

    // Saturating grant counters; clear has priority over increment.
    always_ff @(posedge clk) begin
        if (!rst || stat_clr) begin
            for (int i = 0; i < N_MASTERS; i++) begin
                stat_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_MASTERS; i++) begin
                if (grant_start && winner == IDX_W'(i) && stat_cnt[i] != 32'hFFFF_FFFF) begin
                    stat_cnt[i] <= stat_cnt[i] + 32'd1;
                end
            end
        end
    end

    // Pack counters for the output port, master 0 in the LSBs.
    always_comb begin
        stat_grants = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            stat_grants[i*32 +: 32] = stat_cnt[i];
        end
    end
`endif

endmodule
